// File: rtl/rv32_imem_ahb_slave.sv
// ---------------------------------------------------------------------------
// rv32_imem_ahb_slave
//
// AHB-Lite instruction-memory responder for the core's fetch path. It accepts
// word-aligned read transfers and returns the instruction word after
// WAIT_STATES HREADY-low cycles. Illegal transfers get a two-cycle ERROR
// response. A side-band load port programs the memory independently of the
// bus.
//
// Parameters:
//   DEPTH       memory size in 32-bit words (power of two)
//   AW          word-index width, log2(DEPTH)
//   BASE_ADDR   byte address of word 0 (word aligned)
//   WAIT_STATES HREADY-low cycles per OKAY transfer, 0..15
//
// Ports:
//   clk_in      clock, rising edge
//   rst_in      asynchronous active-low reset
//   hsel_in     slave select
//   haddr_in    transfer byte address
//   htrans_in   IDLE/BUSY/NONSEQ/SEQ
//   hwrite_in   write flag (always illegal here)
//   hsize_in    transfer size (only word is legal)
//   hready_in   muxed bus HREADY, qualifies the address phase
//   hrdata_out  registered read data
//   hready_out  data-phase complete
//   hresp_out   0 = OKAY, 1 = ERROR
//   ld_en_in    load-port write strobe
//   ld_addr_in  load-port word index
//   ld_data_in  load-port data
// ---------------------------------------------------------------------------
module rv32_imem_ahb_slave #(
  parameter int          DEPTH       = 1024,
  parameter int          AW          = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          hsel_in,
  input  logic [31:0]   haddr_in,
  input  logic [1:0]    htrans_in,
  input  logic          hwrite_in,
  input  logic [2:0]    hsize_in,
  input  logic          hready_in,
  output logic [31:0]   hrdata_out,
  output logic          hready_out,
  output logic          hresp_out,
  input  logic          ld_en_in,
  input  logic [AW-1:0] ld_addr_in,
  input  logic [31:0]   ld_data_in
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  // Counter preload for the WAIT state; the counter reaching zero marks the
  // last low cycle, so WAIT_STATES low cycles need WAIT_STATES-1 as preload.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [31:0] mem [DEPTH];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0] hrdata_q, hrdata_d;

  logic          accept;
  logic [31:0]   offset;
  logic          below_base;
  logic          above_top;
  logic          misaligned;
  logic          illegal;
  logic [AW-1:0] addr_idx;
  logic          capture;
  logic [AW-1:0] cap_idx;

  // Address-phase decode. Only NONSEQ/SEQ with select and bus HREADY count.
  // The range check uses the base-relative offset: any bit above the word
  // index range set means the address lies past the top of memory.
  // Misalignment checks both the raw address and the offset; they agree for
  // a word-aligned base.
  always_comb begin
    accept     = hsel_in & hready_in &
                 ((htrans_in == HTRANS_NONSEQ) | (htrans_in == HTRANS_SEQ));
    offset     = haddr_in - BASE_ADDR;
    below_base = (haddr_in < BASE_ADDR);
    above_top  = |offset[31:AW+2];
    misaligned = (|haddr_in[1:0]) | (|offset[1:0]);
    illegal    = hwrite_in | (hsize_in != HSIZE_WORD) | misaligned |
                 below_base | above_top;
    addr_idx   = offset[AW+1:2];
  end

  // State register with the wait counter and the latched word index.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic. IDLE, DATA and ERR2 all complete a data phase with
  // HREADY high, so each of them may take the next address phase.
  // capture/cap_idx select the word that lands in hrdata on the edge that
  // enters DATA: the live address with no wait states, else the index
  // latched at accept time.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    capture = 1'b0;
    cap_idx = addr_idx;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept) begin
          if (illegal) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = ST_DATA;
            capture = 1'b1;
            cap_idx = addr_idx;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
            idx_d   = addr_idx;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DATA;
          capture = 1'b1;
          cap_idx = idx_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Response outputs depend on state only, so an asynchronous reset forces
  // HREADY high immediately.
  always_comb begin
    hready_out = 1'b1;
    hresp_out  = 1'b0;
    case (state_q)
      ST_WAIT: begin
        hready_out = 1'b0;
      end
      ST_ERR1: begin
        hready_out = 1'b0;
        hresp_out  = 1'b1;
      end
      ST_ERR2: begin
        hresp_out  = 1'b1;
      end
      default: begin
        hready_out = 1'b1;
        hresp_out  = 1'b0;
      end
    endcase
  end

  // Read data holds except on the capture edge. The memory read sees the
  // pre-edge contents, so a same-edge load write returns the old word.
  always_comb begin
    hrdata_d = hrdata_q;
    if (capture) begin
      hrdata_d = mem[cap_idx];
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hrdata_q <= 32'h0;
    end else begin
      hrdata_q <= hrdata_d;
    end
  end

  assign hrdata_out = hrdata_q;

  // Load port: memory is deliberately not reset so boot code survives a
  // core reset.
  always_ff @(posedge clk_in) begin
    if (ld_en_in) begin
      mem[ld_addr_in] <= ld_data_in;
    end
  end

endmodule

// File: tb/tb_rv32_imem_ahb_slave.sv
// ---------------------------------------------------------------------------
// tb_rv32_imem_ahb_slave
//
// Drives two instances of the instruction-memory slave (zero and two wait
// states) that share the load port and address bus but have separate selects.
// A flat word array models memory; expected responses come from the address
// legality rules and the configured wait-state count.
// ---------------------------------------------------------------------------
module tb_rv32_imem_ahb_slave;

  localparam int          DEPTH = 1024;
  localparam int          AW    = 10;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic          clk;
  logic          rst_n;
  logic          hsel0, hsel2;
  logic [31:0]   haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;

  logic [31:0]   hrdata0, hrdata2;
  logic          hready0, hready2;
  logic          hresp0,  hresp2;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_rdata0;
  logic [31:0] exp_rdata2;

  rv32_imem_ahb_slave #(
    .DEPTH(DEPTH), .AW(AW), .BASE_ADDR(BASE), .WAIT_STATES(0)
  ) dut0 (
    .clk_in(clk), .rst_in(rst_n), .hsel_in(hsel0), .haddr_in(haddr),
    .htrans_in(htrans), .hwrite_in(hwrite), .hsize_in(hsize),
    .hready_in(hready0), .hrdata_out(hrdata0), .hready_out(hready0),
    .hresp_out(hresp0), .ld_en_in(ld_en), .ld_addr_in(ld_addr),
    .ld_data_in(ld_data)
  );

  rv32_imem_ahb_slave #(
    .DEPTH(DEPTH), .AW(AW), .BASE_ADDR(BASE), .WAIT_STATES(2)
  ) dut2 (
    .clk_in(clk), .rst_in(rst_n), .hsel_in(hsel2), .haddr_in(haddr),
    .htrans_in(htrans), .hwrite_in(hwrite), .hsize_in(hsize),
    .hready_in(hready2), .hrdata_out(hrdata2), .hready_out(hready2),
    .hresp_out(hresp2), .ld_en_in(ld_en), .ld_addr_in(ld_addr),
    .ld_data_in(ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish, observed=running required=finished");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit isLegal(input logic [31:0] a, input logic w,
                                 input logic [2:0] s);
    longint unsigned lo = longint'(BASE);
    longint unsigned hi = longint'(BASE) + 4 * DEPTH;
    longint unsigned av = longint'(a);
    return (!w) && (s == 3'b010) && (a[1:0] == 2'b00) && (av >= lo) && (av < hi);
  endfunction

  function automatic int wordIndex(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic loadWord(input int idx, input logic [31:0] data);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = AW'(idx);
    ld_data = data;
    @(posedge clk);
    model_mem[idx] = data;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic busIdle();
    hsel0  = 1'b0;
    hsel2  = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'b010;
  endtask

  // One isolated transfer on unit 0 (no wait) or unit 2 (two waits), checked
  // through every data-phase cycle against the model.
  task automatic applyStimulus(input int unit, input logic [31:0] addr,
                               input logic wr, input logic [2:0] size,
                               input string tag);
    int ws;
    logic [31:0] exp_d;
    bit legal;
    ws    = (unit == 0) ? 0 : 2;
    legal = isLegal(addr, wr, size);
    @(negedge clk);
    haddr  = addr;
    htrans = 2'b10;
    hwrite = wr;
    hsize  = size;
    hsel0  = (unit == 0);
    hsel2  = (unit != 0);
    @(posedge clk);
    @(negedge clk);
    busIdle();
    exp_d = (unit == 0) ? exp_rdata0 : exp_rdata2;
    if (!legal) begin
      checkOutput({tag, " err1 hready"}, 32'((unit == 0) ? hready0 : hready2), 32'd0);
      checkOutput({tag, " err1 hresp"},  32'((unit == 0) ? hresp0  : hresp2),  32'd1);
      checkOutput({tag, " err1 hrdata"}, (unit == 0) ? hrdata0 : hrdata2, exp_d);
      @(negedge clk);
      checkOutput({tag, " err2 hready"}, 32'((unit == 0) ? hready0 : hready2), 32'd1);
      checkOutput({tag, " err2 hresp"},  32'((unit == 0) ? hresp0  : hresp2),  32'd1);
      checkOutput({tag, " err2 hrdata"}, (unit == 0) ? hrdata0 : hrdata2, exp_d);
    end else begin
      for (int k = 0; k < ws; k++) begin
        checkOutput({tag, " wait hready"}, 32'((unit == 0) ? hready0 : hready2), 32'd0);
        checkOutput({tag, " wait hresp"},  32'((unit == 0) ? hresp0  : hresp2),  32'd0);
        @(negedge clk);
      end
      exp_d = model_mem[wordIndex(addr)];
      if (unit == 0) exp_rdata0 = exp_d;
      else           exp_rdata2 = exp_d;
      checkOutput({tag, " data hready"}, 32'((unit == 0) ? hready0 : hready2), 32'd1);
      checkOutput({tag, " data hresp"},  32'((unit == 0) ? hresp0  : hresp2),  32'd0);
      checkOutput({tag, " data hrdata"}, (unit == 0) ? hrdata0 : hrdata2, exp_d);
    end
  endtask

  initial begin
    logic [31:0] old5;
    logic [31:0] raddr;
    logic        rwr;
    logic [2:0]  rsize;
    int          runit;

    rst_n   = 1'b0;
    ld_en   = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    haddr   = '0;
    busIdle();
    exp_rdata0 = 32'h0;
    exp_rdata2 = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state.
    checkOutput("reset hready0", 32'(hready0), 32'd1);
    checkOutput("reset hresp0",  32'(hresp0),  32'd0);
    checkOutput("reset hrdata0", hrdata0, 32'h0);
    checkOutput("reset hready2", 32'(hready2), 32'd1);
    checkOutput("reset hrdata2", hrdata2, 32'h0);

    // Fill memory with random contents so every read has a known answer.
    for (int i = 0; i < DEPTH; i++) loadWord(i, $urandom);

    // Single zero-wait read.
    loadWord(0, 32'h0000_0013);
    applyStimulus(0, 32'h0, 1'b0, 3'b010, "single");

    // Pipelined burst: NONSEQ then three SEQ on consecutive cycles.
    for (int i = 0; i < 4; i++) loadWord(i, 32'hA0 + 32'(i));
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checkOutput("burst hready", 32'(hready0), 32'd1);
        checkOutput("burst hrdata", hrdata0, model_mem[i-1]);
        exp_rdata0 = model_mem[i-1];
      end
      if (i < 4) begin
        haddr  = 32'(i * 4);
        htrans = (i == 0) ? 2'b10 : 2'b11;
        hwrite = 1'b0;
        hsize  = 3'b010;
        hsel0  = 1'b1;
      end else begin
        busIdle();
      end
    end

    // Wait states with the next address phase held during the stall.
    @(negedge clk);
    haddr = 32'h4; htrans = 2'b10; hwrite = 1'b0; hsize = 3'b010; hsel2 = 1'b1;
    @(negedge clk);
    haddr = 32'h8;
    checkOutput("ws first low", 32'(hready2), 32'd0);
    @(negedge clk);
    checkOutput("ws second low", 32'(hready2), 32'd0);
    @(negedge clk);
    checkOutput("ws data hready", 32'(hready2), 32'd1);
    checkOutput("ws data word1", hrdata2, model_mem[1]);
    @(negedge clk);
    busIdle();
    checkOutput("ws held low a", 32'(hready2), 32'd0);
    @(negedge clk);
    checkOutput("ws held low b", 32'(hready2), 32'd0);
    @(negedge clk);
    checkOutput("ws held word2", hrdata2, model_mem[2]);
    exp_rdata2 = model_mem[2];

    // Error responses.
    applyStimulus(0, 32'h2, 1'b0, 3'b010, "err misaligned");
    applyStimulus(0, 32'h0, 1'b1, 3'b010, "err write");
    applyStimulus(0, 32'(4 * DEPTH), 1'b0, 3'b010, "err range");
    applyStimulus(2, 32'h6, 1'b0, 3'b001, "err size ws");

    // Reset asserted during WAIT.
    @(negedge clk);
    haddr = 32'hC; htrans = 2'b10; hwrite = 1'b0; hsize = 3'b010; hsel2 = 1'b1;
    @(negedge clk);
    busIdle();
    checkOutput("rst in wait", 32'(hready2), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst async hready", 32'(hready2), 32'd1);
    checkOutput("rst async hresp",  32'(hresp2),  32'd0);
    checkOutput("rst async hrdata", hrdata2, 32'h0);
    exp_rdata0 = 32'h0;
    exp_rdata2 = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post rst hready", 32'(hready2), 32'd1);
    applyStimulus(2, 32'hC, 1'b0, 3'b010, "post rst read");

    // Load write and read capture of word 5 on the same edge.
    old5 = model_mem[5];
    @(negedge clk);
    haddr = 32'h14; htrans = 2'b10; hwrite = 1'b0; hsize = 3'b010; hsel0 = 1'b1;
    ld_en = 1'b1; ld_addr = AW'(5); ld_data = ~old5;
    @(posedge clk);
    model_mem[5] = ~old5;
    @(negedge clk);
    busIdle();
    ld_en = 1'b0;
    checkOutput("collision old", hrdata0, old5);
    exp_rdata0 = old5;
    applyStimulus(0, 32'h14, 1'b0, 3'b010, "collision new");

    // Randomized transfers with occasional reloads.
    for (int n = 0; n < 60; n++) begin
      runit = ($urandom_range(0, 1) == 0) ? 0 : 2;
      case ($urandom_range(0, 5))
        0, 1, 2: raddr = 32'($urandom_range(0, DEPTH - 1)) * 4;
        3:       raddr = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
        4:       raddr = 32'(4 * DEPTH) + 32'($urandom_range(0, 1000)) * 4;
        default: raddr = $urandom;
      endcase
      rwr   = ($urandom_range(0, 7) == 0);
      rsize = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      if ($urandom_range(0, 3) == 0) loadWord(int'($urandom_range(0, DEPTH - 1)), $urandom);
      applyStimulus(runit, raddr, rwr, rsize, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32_imem_ahb_slave.md
# rv32_imem_ahb_slave

AHB-Lite instruction-memory responder: the target end of the instruction-fetch bus driven by the core's PC/fetch path. It accepts word-aligned read transfers, returns the instruction word after a configurable number of wait states, and signals a two-cycle ERROR response for illegal transfers. A side-band load port lets the testbench or boot logic program the memory.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words; must be a power of two.
- `AW`, 10: word-index width, log2(DEPTH).
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0. Matches the core boot address.
- `WAIT_STATES`, 0: HREADY-low cycles inserted per OKAY transfer, range 0–15.

- `clk_in`  in  1  clock; all state updates on the rising edge.
- `rst_in`  in  1  reset; asynchronous, active-low.
- `hsel_in`  in  1  slave select.
- `haddr_in`  in  32  transfer byte address.
- `htrans_in`  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `hwrite_in`  in  1  1 = write; always illegal for this slave.
- `hsize_in`  in  3  transfer size; only 3'b010 (word) is legal.
- `hready_in`  in  1  bus HREADY (muxed); qualifies the address phase.
- `hrdata_out`  out  32  read data.
- `hready_out`  out  1  data-phase complete.
- `hresp_out`  out  1  0 = OKAY, 1 = ERROR.
- `ld_en_in`  in  1  load-port write strobe.
- `ld_addr_in`  in  AW  load-port word index.
- `ld_data_in`  in  32  load-port data.

## Operation
- **Accept.** An address phase is accepted on an edge where `hsel_in & htrans_in[1] & hready_in` is 1.
  - IDLE or BUSY transfers, or `hsel_in` = 0, are never accepted.
  - If nothing is pending, such cycles get a zero-wait OKAY.
- **Illegal transfer.** An accepted transfer is illegal if any of these hold:
  - `hwrite_in` = 1
  - `hsize_in` ≠ 3'b010
  - `haddr_in[1:0]` ≠ 0
  - `haddr_in` < `BASE_ADDR`
  - `haddr_in` ≥ `BASE_ADDR` + 4·`DEPTH`
- **Word index.** `(haddr_in - BASE_ADDR) >> 2`, truncated to `AW` bits. It is used only for legal transfers.
- **FSM states.** IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: `hready_out`=1, `hresp_out`=0.
    - Accept of an illegal transfer → ERR1.
    - Accept of a legal transfer with `WAIT_STATES`=0 → DATA.
    - Accept of a legal transfer with `WAIT_STATES`>0 → WAIT, with the wait counter loaded to `WAIT_STATES`-1.
  - WAIT: `hready_out`=0, `hresp_out`=0. Counter decrements each cycle; when the counter is 0 → DATA.
  - DATA: `hready_out`=1, `hresp_out`=0, `hrdata_out` valid. A new accept in this cycle follows the same branching as IDLE; otherwise → IDLE.
  - ERR1: `hready_out`=0, `hresp_out`=1. Always → ERR2.
  - ERR2: `hready_out`=1, `hresp_out`=1. A new accept follows the IDLE branching; otherwise → IDLE.
- **Read data.**
  - `hrdata_out` is registered. It loads `mem[index]` on the edge entering DATA.
  - It holds its value in every other state. ERROR responses do not change it.
- **Load port.**
  - `ld_en_in`=1 writes `mem[ld_addr_in]` at the clock edge.
  - The write is independent of the bus FSM.
  - If a load write and a read-capture hit the same word on the same edge, the read returns the old contents.
- **Memory reset.** Memory contents are not affected by reset.

## Timing
- **Reset values.** `hready_out`=1, `hresp_out`=0, `hrdata_out`=0, FSM=IDLE, wait counter=0.
- **Reset mid-operation.** Assertion takes effect immediately and asynchronously. An in-flight transfer is abandoned with no response; `hready_out` returns to 1 without waiting for a clock edge.
- **Latency.** With the address phase on cycle N, the OKAY data phase completes on cycle N+1+`WAIT_STATES`.
- **Throughput.**
  - `WAIT_STATES`=0: back-to-back NONSEQ/SEQ reads sustain one word per cycle.
  - Otherwise: one word per 1+`WAIT_STATES` cycles.
- **ERROR response.** Always exactly 2 data-phase cycles (ERR1, then ERR2). The address phase overlapping ERR2 is accepted normally.
- **Stalled address phase.** An address phase presented while `hready_in`=0 (e.g. during WAIT or ERR1) is not accepted. The master must hold it until `hready_in`=1.

## Test plan
- **Reset state.** After `rst_in` deasserts, with no transfer: `hready_out`=1, `hresp_out`=0, `hrdata_out`=32'h0.
- **Single read, zero wait.**
  - Setup: load word 0 = 32'h0000_0013; `WAIT_STATES`=0.
  - Stimulus: NONSEQ read at 32'h0.
  - Required: next cycle `hready_out`=1, `hresp_out`=0, `hrdata_out`=32'h0000_0013.
- **Pipelined burst.**
  - Setup: words 0–3 loaded with 32'hA0..A3.
  - Stimulus: NONSEQ at 0, then SEQ at 4, 8, 12 on consecutive cycles.
  - Required: data 32'hA0..A3 on four consecutive cycles, `hready_out` held at 1.
- **Wait states.**
  - Setup: `WAIT_STATES`=2.
  - Stimulus: read at 32'h4.
  - Required: `hready_out`=0 for 2 cycles, then 1 with word 1; the next address phase is held until `hready_in`=1.
- **Error responses.**
  - Stimuli: read at 32'h2; write at 32'h0; read at 4·`DEPTH`.
  - Required for each: ERR1 (`hready_out`=0, `hresp_out`=1), then ERR2 (`hready_out`=1, `hresp_out`=1); `hrdata_out` unchanged.
- **Reset mid-WAIT and load/read collision.**
  - Stimulus A: assert `rst_in` low during WAIT. Required: `hready_out`=1 immediately; FSM in IDLE.
  - Stimulus B: a load write to word 5 on the same edge as the capture of word 5. Required: the read returns the old value.
